reset_sequencer: RTL and testbench

//  Parametrised reset controller; successor to the fixed toplevel reset counter plus single-button falling-edge sync_reset.

---
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset controller: synchronises the PLL lock and external reset pins, debounces
// the pins, merges them with a software request, stretches the combined request
// and then releases the reset domains one after another, domain 0 first.
// A sticky cause vector records which request bit triggered the last reset.
module reset_sequencer #(
    parameter int                 NUM_SRC         = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MODE       = 2'b01,
    parameter int                 DEBOUNCE_CYCLES = 1000,
    parameter int                 STRETCH_CYCLES  = 255,
    parameter int                 NUM_DOMAINS     = 2,
    parameter int                 STAGGER_CYCLES  = 16
) (
    input  logic                   io_mainClk,
    input  logic                   io_asyncResetN,
    input  logic                   io_pllLocked,
    input  logic [NUM_SRC-1:0]     io_srcIn,
    input  logic                   io_swReq,
    input  logic                   io_causeClr,
    output logic [NUM_DOMAINS-1:0] io_resetOut,
    output logic                   io_ready,
    output logic [NUM_SRC+1:0]     io_cause
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W  = $clog2(STRETCH_CYCLES + 1);
    localparam int SG_W  = $clog2(STAGGER_CYCLES + 1);
    localparam int CNT_W = (ST_W > SG_W) ? ST_W : SG_W;
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic [1:0]             pll_sync_reg;
    logic                   pll_locked_s;
    logic [NUM_SRC-1:0]     req_src;
    logic                   req_any;
    logic [NUM_SRC+1:0]     cause_set;
    logic [NUM_SRC+1:0]     cause_reg;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NUM_DOMAINS-1:0] reset_out_reg;
    logic                   ready_reg;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            pll_sync_reg <= '0;
        end else begin
            pll_sync_reg <= {pll_sync_reg[0], io_pllLocked};
        end
    end

    assign pll_locked_s = pll_sync_reg[1];

    // One synchroniser, debouncer and request generator per external source.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [1:0]      sync_reg;
        logic [DB_W-1:0] db_cnt_reg;
        logic            filt_reg;

        // Synchronise the pin, then let the filtered value follow only after the
        // synchronised value has disagreed with it for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
            if (!io_asyncResetN) begin
                sync_reg   <= '0;
                db_cnt_reg <= '0;
                filt_reg   <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[0], io_srcIn[gi]};
                if (sync_reg[1] == filt_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_reg   <= sync_reg[1];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_W'(1);
                end
            end
        end

        if (EDGE_MODE[gi]) begin : g_edge
            logic filt_d_reg;

            // Previous filtered value, so a release (1->0) yields a one-cycle request.
            always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
                if (!io_asyncResetN) begin
                    filt_d_reg <= 1'b0;
                end else begin
                    filt_d_reg <= filt_reg;
                end
            end

            assign req_src[gi] = filt_d_reg & ~filt_reg;
        end else begin : g_level
            assign req_src[gi] = filt_reg;
        end
    end

    assign req_any   = ~pll_locked_s | io_swReq | (|req_src);
    assign cause_set = {req_src, io_swReq, ~pll_locked_s};

    // Sticky cause bits; a set in the same cycle as a clear takes priority.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            cause_reg <= '0;
        end else begin
            cause_reg <= (io_causeClr ? '0 : cause_reg) | cause_set;
        end
    end

    // Sequencer: hold while any request is present, stretch, then stagger releases.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            state_reg     <= HOLD;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            reset_out_reg <= '1;
            ready_reg     <= 1'b0;
        end else if (req_any) begin
            state_reg     <= HOLD;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            reset_out_reg <= '1;
            ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    state_reg <= STRETCH;
                    cnt_reg   <= '0;
                end
                STRETCH: begin
                    if (cnt_reg == CNT_W'(STRETCH_CYCLES - 1)) begin
                        state_reg <= RELEASE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_reg == CNT_W'(STAGGER_CYCLES - 1)) begin
                        cnt_reg                <= '0;
                        reset_out_reg[idx_reg] <= 1'b0;
                        if (idx_reg == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_reg <= RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    reset_out_reg <= '0;
                    ready_reg     <= 1'b1;
                end
                default: begin
                    state_reg     <= HOLD;
                    cnt_reg       <= '0;
                    idx_reg       <= '0;
                    reset_out_reg <= '1;
                    ready_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign io_resetOut = reset_out_reg;
    assign io_ready    = ready_reg;
    assign io_cause    = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by random stimulus.
// A reference model pushes the expected outputs after every clock edge; a
// monitor pops them on the falling edge and compares against the DUT.
module tb_reset_sequencer;

    localparam int                NSRC = 2;
    localparam logic [NSRC-1:0]   EM   = 2'b10;
    localparam int                DEB  = 4;
    localparam int                STR  = 8;
    localparam int                NDOM = 2;
    localparam int                STG  = 4;

    typedef struct {
        logic [NDOM-1:0] ro;
        logic            rdy;
        logic [NSRC+1:0] cause;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            pll;
    logic [NSRC-1:0] src;
    logic            sw;
    logic            clr;
    logic [NDOM-1:0] reset_out;
    logic            ready;
    logic [NSRC+1:0] cause;

    int   total;
    int   bad;
    exp_t exp_q[$];

    // Model state
    logic [1:0]      m_pll;
    logic [1:0]      m_sync [NSRC];
    logic [DEB-1:0]  m_hist [NSRC];
    logic [NSRC-1:0] m_filt;
    logic [NSRC-1:0] m_fprev;
    logic [NSRC+1:0] m_cause;
    int              m_n;

    reset_sequencer #(
        .NUM_SRC        (NSRC),
        .EDGE_MODE      (EM),
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR),
        .NUM_DOMAINS    (NDOM),
        .STAGGER_CYCLES (STG)
    ) dut (
        .io_mainClk    (clk),
        .io_asyncResetN(rst_n),
        .io_pllLocked  (pll),
        .io_srcIn      (src),
        .io_swReq      (sw),
        .io_causeClr   (clr),
        .io_resetOut   (reset_out),
        .io_ready      (ready),
        .io_cause      (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. m_n counts consecutive edges without any request; the
    // outputs follow from it: domain d is out of reset once the quiet run covers
    // the HOLD exit, the stretch and (d+1) stagger intervals.
    initial begin : model
        exp_t            e;
        logic [NSRC-1:0] req;
        logic            any;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pll   = '0;
                m_filt  = '0;
                m_fprev = '0;
                m_cause = '0;
                m_n     = 0;
                for (int i = 0; i < NSRC; i++) begin
                    m_sync[i] = '0;
                    m_hist[i] = '0;
                end
            end else begin
                for (int i = 0; i < NSRC; i++)
                    req[i] = EM[i] ? (m_fprev[i] & ~m_filt[i]) : m_filt[i];
                any     = ~m_pll[1] | sw | (|req);
                m_cause = (clr ? '0 : m_cause) | {req, sw, ~m_pll[1]};
                if (any) m_n = 0;
                else if (m_n < 100000) m_n = m_n + 1;
                m_pll = {m_pll[0], pll};
                for (int i = 0; i < NSRC; i++) begin
                    m_hist[i]  = {m_hist[i][DEB-2:0], m_sync[i][1]};
                    m_fprev[i] = m_filt[i];
                    if (m_hist[i] == {DEB{~m_filt[i]}}) m_filt[i] = ~m_filt[i];
                    m_sync[i] = {m_sync[i][0], src[i]};
                end
            end
            for (int d = 0; d < NDOM; d++)
                e.ro[d] = !(m_n >= 1 + STR + (d + 1) * STG);
            e.rdy   = (m_n >= 1 + STR + NDOM * STG);
            e.cause = m_cause;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs with the oldest expectation on each falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!rst_n) begin
                    e.ro    = '1;
                    e.rdy   = 1'b0;
                    e.cause = '0;
                end
                total++;
                if (reset_out !== e.ro) begin
                    bad++;
                    $display("FAIL resetOut t=%0t got=%b exp=%b", $time, reset_out, e.ro);
                end
                total++;
                if (ready !== e.rdy) begin
                    bad++;
                    $display("FAIL ready t=%0t got=%b exp=%b", $time, ready, e.rdy);
                end
                total++;
                if (cause !== e.cause) begin
                    bad++;
                    $display("FAIL cause t=%0t got=%b exp=%b", $time, cause, e.cause);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sw();
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
    endtask

    initial begin : stim
        bit found;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        pll   = 1'b0;
        src   = '0;
        sw    = 1'b0;
        clr   = 1'b0;
        tick(3);
        #2 rst_n = 1'b1;

        // 1: PLL lock arrives late, full release sequence follows
        tick(10);
        pll = 1'b1;
        $display("phase 1: pll lock rises at t=%0t", $time);
        tick(40);

        // 2: level source, short glitch ignored, long press resets
        src[0] = 1'b1;
        tick(3);
        src[0] = 1'b0;
        $display("phase 2a: src0 glitch of 3 cycles at t=%0t", $time);
        tick(20);
        src[0] = 1'b1;
        tick(4);
        src[0] = 1'b0;
        $display("phase 2b: src0 held 4 cycles at t=%0t", $time);
        tick(40);

        // 3: edge source held long, reset only on release
        src[1] = 1'b1;
        tick(100);
        src[1] = 1'b0;
        $display("phase 3: src1 released after 100 cycles at t=%0t", $time);
        tick(40);

        // 4: software request after domain 0 has been released
        pulse_sw();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick(1);
            if (reset_out == 2'b10) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_release got=timeout exp=resetOut 10");
        end
        pulse_sw();
        $display("phase 4: swReq during RELEASE at t=%0t", $time);
        tick(40);

        // 5: clear collides with set, then clear alone
        sw  = 1'b1;
        clr = 1'b1;
        tick(1);
        sw  = 1'b0;
        clr = 1'b0;
        tick(30);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        $display("phase 5: causeClr with and without swReq at t=%0t", $time);
        tick(5);

        // 6: asynchronous reset mid-STRETCH
        pulse_sw();
        tick(4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (reset_out !== '1 || ready !== 1'b0 || cause !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%b exp=11/0/0000", reset_out, ready, cause);
        end
        @(posedge clk);
        #4 rst_n = 1'b1;
        $display("phase 6: async reset pulse ended at t=%0t", $time);
        tick(40);

        // Random stimulus
        for (int k = 0; k < 80; k++) begin
            int act;
            int len;
            act = $urandom_range(0, 5);
            len = $urandom_range(1, 8);
            case (act)
                0: pulse_sw();
                1: begin clr = 1'b1; tick(1); clr = 1'b0; end
                2: begin
                    int s;
                    s = $urandom_range(0, NSRC - 1);
                    src[s] = 1'b1;
                    tick(len);
                    src[s] = 1'b0;
                end
                3: begin pll = 1'b0; tick(len); pll = 1'b1; end
                4: begin sw = 1'b1; clr = 1'b1; tick(1); sw = 1'b0; clr = 1'b0; end
                default: ;
            endcase
            $display("random %0d: act=%0d len=%0d t=%0t", k, act, len, $time);
            tick($urandom_range(0, 35));
        end
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
